inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Consumer end of the PC interface: takes the fetch address produced by the PC register each cycle,
//  issues it to instruction memory over a valid/ready request channel, and collects in-order responses
//  into a small slot queue. Delivers {pc, inst} to decode with a valid/ready handshake.
//  Drops in-flight responses on a branch redirect (flush). Asserts stall back to the PC register.
// PARAMETERS
//  W      `WORD_WIDTH  address / instruction width
//  DEPTH  2            slot-queue entries = max in-flight + buffered instructions (power of 2, >=2)
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  pc             in   W      fetch address from PC register
//  pc_valid       in   1      pc is meaningful this cycle
//  flush          in   1      branch redirect; kill all fetched/in-flight work
//  pc_stall       out  1      PC must hold: pc_valid && !pc_accept
//  imem_req_valid out  1      request valid
//  imem_req_ready in   1      memory accepts request
//  imem_req_addr  out  W      = pc
//  imem_resp_valid in  1      response valid; responses return strictly in request order
//  imem_resp_data in   W      instruction word
//  if_valid       out  1      head slot filled
//  if_pc          out  W      head slot address
//  if_inst        out  W      head slot instruction
//  id_ready       in   1      decode accepts head
// BEHAVIOUR
//  Reset: all slots invalid, count=0, drop_cnt=0; if_valid=0, if_pc=`ZERO_WORD, if_inst=`NOP_INST,
//   imem_req_valid=0, pc_stall=0. Reset mid-operation discards everything; imem must be reset with it.
//  Slot = {alloc, filled, pc, inst}. Circular queue, head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
//  pop = if_valid && id_ready && !flush.
//  Request: imem_req_valid = pc_valid && !flush && !rst && (count < DEPTH || pop).
//   pc_accept = imem_req_valid && imem_req_ready -> allocate slot at tail (alloc=1, filled=0, pc).
//  Response: if drop_cnt>0 -> discard, drop_cnt-1. Else fill oldest allocated-unfilled slot (fill ptr).
//   Response with no unfilled slot and drop_cnt==0 is a protocol error (assertion only).
//  Output: if_valid = head alloc && filled; if_pc/if_inst driven from head registers (no bypass);
//   if_inst = `NOP_INST when !if_valid.
//  Latency: request accepted cycle N, response N+1 -> if_valid at N+2.
//  Throughput: DEPTH=2 with 1-cycle memory and id_ready=1 sustains 1 inst/cycle (pop frees credit same cycle).
//  Flush: next cycle all slots cleared, count=0, pointers to 0, no pop, no request;
//   drop_cnt_next = drop_cnt + unfilled_count - (imem_resp_valid ? 1 : 0) (same-cycle response is killed).
//   Already-accepted-but-unanswered requests are thus always dropped, never delivered.
//  Simultaneous pop+allocate when full: permitted, count unchanged.
//  drop_cnt width clog2(DEPTH+1); saturation impossible since in-flight <= DEPTH.
//  imem_req_valid, once high, is not required to stay high (flush may withdraw it).
// STRUCTURE
//  defines.v: `WORD_WIDTH, `ZERO_WORD, add `NOP_INST (32'h0000_0000).
//  Sub-module fetch_slot_queue: alloc/fill/pop pointers, per-slot flags, clear-on-flush, count.
//  Top: request gating, drop counter, pc_stall, output muxing.
// TESTING
//  1. Reset then pc=0,4,8.. valid, ready=1, 1-cycle mem, id_ready=1 -> if_pc 0,4,8 one per cycle from cycle 2.
//  2. id_ready=0 after 2 accepts -> count=2, pc_stall=1, imem_req_valid=0; id_ready=1 -> resume, no loss/dup.
//  3. imem_req_ready=0 for 3 cycles -> pc_stall=1, pc held, if_valid drops then resumes in order.
//  4. Flush with 2 requests in flight, no same-cycle resp -> drop_cnt=2, next 2 responses discarded,
//     first post-flush pc 0x100 delivered with its own inst.
//  5. Flush coinciding with resp_valid and 1 other in flight -> drop_cnt=1; only post-flush insts appear.
//  6. rst asserted with full queue and in-flight requests -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and slot types for the instruction fetch unit.
// Word width, the reset word and the NOP instruction live here so every fetch file agrees on them.
package inst_fetch_unit_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int FETCH_DEPTH = 2;

    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [WORD_WIDTH-1:0] NOP_INST  = 32'h0000_0000;

    // alloc: a request owns the slot; filled: its instruction word has returned
    typedef struct packed {
        logic alloc;
        logic filled;
    } slot_flags_t;

    localparam slot_flags_t SLOT_EMPTY   = '{alloc: 1'b0, filled: 1'b0};
    localparam slot_flags_t SLOT_WAITING = '{alloc: 1'b1, filled: 1'b0};

    function automatic logic slot_waiting(input slot_flags_t f);
        return f.alloc && !f.filled;
    endfunction

    function automatic logic slot_ready(input slot_flags_t f);
        return f.alloc && f.filled;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_slot_queue.sv
// Circular slot queue for in-order fetch: allocate at tail, fill at the oldest waiting slot,
// pop at head. Clearing empties every slot and returns all pointers to zero.
module fetch_slot_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int W     = WORD_WIDTH,
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_alloc,
    input  logic [W-1:0]  i_alloc_pc,
    input  logic          i_fill,
    input  logic [W-1:0]  i_fill_inst,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_unfilled,
    output logic          o_fill_avail,
    output logic          o_head_valid,
    output logic [W-1:0]  o_head_pc,
    output logic [W-1:0]  o_head_inst
);

    slot_flags_t   r_flags [DEPTH];
    logic [W-1:0]  r_pc    [DEPTH];
    logic [W-1:0]  r_inst  [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_fill;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_unfilled;
    logic          w_fill_avail;
    logic          w_do_fill;

    always_comb begin
        w_unfilled = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_waiting(r_flags[i])) begin
                w_unfilled = w_unfilled + CW'(1);
            end
        end
    end

    // Responses return in request order, so the fill pointer always names the oldest waiting slot.
    assign w_fill_avail = slot_waiting(r_flags[r_fill]);
    assign w_do_fill    = i_fill && w_fill_avail;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_flags[i] <= SLOT_EMPTY;
                r_pc[i]    <= ZERO_WORD[W-1:0];
                r_inst[i]  <= NOP_INST[W-1:0];
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_fill) begin
                r_flags[r_fill].filled <= 1'b1;
                r_inst[r_fill]         <= i_fill_inst;
                r_fill                 <= r_fill + PW'(1);
            end
            if (i_pop) begin
                r_flags[r_head] <= SLOT_EMPTY;
                r_head          <= r_head + PW'(1);
            end
            // Placed after the pop so a full queue can pop and reallocate the same slot.
            if (i_alloc) begin
                r_flags[r_tail] <= SLOT_WAITING;
                r_pc[r_tail]    <= i_alloc_pc;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(i_alloc) - CW'(i_pop);
        end
    end

    assign o_count      = r_count;
    assign o_unfilled   = w_unfilled;
    assign o_fill_avail = w_fill_avail;
    assign o_head_valid = slot_ready(r_flags[r_head]);
    assign o_head_pc    = r_pc[r_head];
    assign o_head_inst  = r_inst[r_head];

    assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) i_pop |-> o_head_valid);
    assert property (@(posedge clk) disable iff (rst || i_clear)
                     i_alloc |-> (r_count < CW'(DEPTH)) || i_pop);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: gates PC requests into imem by queue credit, tracks responses
// still owed to a flushed stream, and presents the oldest fetched {pc, inst} to decode.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int W     = WORD_WIDTH,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    input  logic         pc_valid,
    input  logic         flush,
    output logic         pc_stall,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [W-1:0] imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [W-1:0] imem_resp_data,
    output logic         if_valid,
    output logic [W-1:0] if_pc,
    output logic [W-1:0] if_inst,
    input  logic         id_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshakes: a transfer happens in any cycle where valid && ready are both high at the clock
    // edge; valid may be withdrawn without a transfer (flush), and responses carry no ready.
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_unfilled;
    logic          w_fill_avail;
    logic          w_head_valid;
    logic [W-1:0]  w_head_pc;
    logic [W-1:0]  w_head_inst;
    logic          w_pop;
    logic          w_accept;
    logic          w_fill;

    // A pop in the same cycle frees a slot, which keeps a 2-deep queue streaming at full rate.
    assign w_pop          = w_head_valid && id_ready && !flush;
    assign imem_req_valid = pc_valid && !flush && !rst && ((w_count < DEPTH_C) || w_pop);
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign pc_stall       = pc_valid && !w_accept && !rst;
    assign imem_req_addr  = pc;

    assign w_fill = imem_resp_valid && (r_drop_cnt == '0) && !flush;

    // Every request still unanswered at a flush owes one response that must be thrown away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(imem_resp_valid);
        end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    fetch_slot_queue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_slot_queue (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (flush),
        .i_alloc      (w_accept),
        .i_alloc_pc   (pc),
        .i_fill       (w_fill),
        .i_fill_inst  (imem_resp_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_fill_avail (w_fill_avail),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_inst  (w_head_inst)
    );

    assign if_valid = w_head_valid;
    assign if_pc    = w_head_pc;
    assign if_inst  = w_head_valid ? w_head_inst : NOP_INST[W-1:0];

    assert property (@(posedge clk) disable iff (rst)
                     (imem_resp_valid && (r_drop_cnt == '0)) |-> w_fill_avail);
    assert property (@(posedge clk) disable iff (rst)
                     (int'(r_drop_cnt) + int'(w_unfilled)) <= DEPTH);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a queue-level fetch model plus an in-order memory
// and PC register environment, checked every cycle, with hand-computed delivery sequences.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc;
    logic         pc_valid;
    logic         flush;
    logic         pc_stall;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [W-1:0] imem_req_addr;
    logic         imem_resp_valid;
    logic [W-1:0] imem_resp_data;
    logic         if_valid;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_inst;
    logic         id_ready;

    inst_fetch_unit #(.W(W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .flush           (flush),
        .pc_stall        (pc_stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Stimulus knobs, applied at the next step
    logic         k_rst, k_pc_valid, k_flush, k_ready, k_id_ready, k_mem_en;
    logic [W-1:0] k_target;
    logic [W-1:0] cur_pc;

    // In-order memory: addresses accepted and not yet answered
    logic [W-1:0] mem_q[$];

    // Fetch model: one entry per outstanding fetch, oldest first
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_inst_q[$];
    logic         exp_fill_q[$];
    int           m_drop;

    // What decode actually received
    logic [W-1:0] got_pc[$];
    logic [W-1:0] got_inst[$];
    int           got_cyc[$];

    logic         s_if_valid, s_req_valid, s_stall;
    logic [W-1:0] s_if_pc, s_if_inst, s_req_addr;

    int t0;

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic         resp, d_acc;
        logic         e_valid, e_pop, e_req, e_acc, e_stall;
        logic [W-1:0] e_inst;
        int           unf, idx;
        @(negedge clk);
        rst            = k_rst;
        pc             = cur_pc;
        pc_valid       = k_pc_valid;
        flush          = k_flush;
        imem_req_ready = k_ready;
        id_ready       = k_id_ready;
        resp           = k_mem_en && !k_rst && (mem_q.size() > 0);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? inst_of(mem_q[0]) : '0;
        #2;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_inst   = if_inst;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_stall     = pc_stall;

        e_valid = (exp_q.size() > 0) && exp_fill_q[0];
        e_inst  = e_valid ? exp_inst_q[0] : NOP_INST;
        e_pop   = e_valid && id_ready && !flush;
        e_req   = pc_valid && !flush && !rst && ((exp_q.size() < DEPTH) || e_pop);
        e_acc   = e_req && imem_req_ready;
        e_stall = pc_valid && !e_acc && !rst;

        if (!k_rst) begin
            chk("if_valid", W'(s_if_valid), W'(e_valid));
            chk("if_inst", s_if_inst, e_inst);
            if (e_valid) chk("if_pc", s_if_pc, exp_q[0]);
            chk("imem_req_valid", W'(s_req_valid), W'(e_req));
            if (e_req) chk("imem_req_addr", s_req_addr, pc);
            chk("pc_stall", W'(s_stall), W'(e_stall));
            if (s_if_valid && id_ready && !flush) begin
                got_pc.push_back(s_if_pc);
                got_inst.push_back(s_if_inst);
                got_cyc.push_back(cyc);
            end
        end
        d_acc = imem_req_valid && imem_req_ready;

        @(posedge clk);
        cyc++;
        if (k_rst) begin
            exp_q.delete(); exp_inst_q.delete(); exp_fill_q.delete();
            m_drop = 0;
        end else if (k_flush) begin
            unf = 0;
            foreach (exp_fill_q[i]) if (!exp_fill_q[i]) unf++;
            m_drop = m_drop + unf - (resp ? 1 : 0);
            exp_q.delete(); exp_inst_q.delete(); exp_fill_q.delete();
        end else begin
            if (resp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    idx = -1;
                    foreach (exp_fill_q[i]) if (!exp_fill_q[i] && idx < 0) idx = i;
                    chk("resp_has_slot", W'(idx >= 0), W'(1));
                    if (idx >= 0) begin
                        exp_fill_q[idx] = 1'b1;
                        exp_inst_q[idx] = imem_resp_data;
                    end
                end
            end
            if (e_pop) begin
                void'(exp_q.pop_front());
                void'(exp_inst_q.pop_front());
                void'(exp_fill_q.pop_front());
            end
            if (e_acc) begin
                exp_q.push_back(pc);
                exp_inst_q.push_back(NOP_INST);
                exp_fill_q.push_back(1'b0);
            end
        end

        if (k_rst) begin
            mem_q.delete();
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (d_acc) mem_q.push_back(pc);
        end
        if (k_flush) cur_pc = k_target;
        else if (e_acc) cur_pc = cur_pc + 32'd4;
    endtask

    task automatic do_reset(input logic [W-1:0] start_pc);
        k_rst = 1'b1; k_flush = 1'b0; k_pc_valid = 1'b0;
        k_ready = 1'b1; k_id_ready = 1'b1; k_mem_en = 1'b1;
        step();
        k_rst = 1'b0;
        cur_pc = start_pc;
        got_pc.delete(); got_inst.delete(); got_cyc.delete();
    endtask

    task automatic chk_seq(input logic [W-1:0] base, input int n);
        chk("delivered_count", W'(got_pc.size()), W'(n));
        for (int k = 0; k < n && k < got_pc.size(); k++) begin
            chk("delivered_pc", got_pc[k], base + W'(4 * k));
            chk("delivered_inst", got_inst[k], 32'h1300_0000 | (base + W'(4 * k)));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_if_valid", W'(s_if_valid), W'(0));
        chk("rst_if_pc", s_if_pc, ZERO_WORD);
        chk("rst_if_inst", s_if_inst, NOP_INST);
        chk("rst_req_valid", W'(s_req_valid), W'(0));
        chk("rst_pc_stall", W'(s_stall), W'(0));
    endtask

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
        k_target = '0; cur_pc = '0; m_drop = 0;

        // Reset values
        do_reset(32'h0);
        step();
        step();
        chk_reset_outputs();

        // 1: streaming one instruction per cycle from the third cycle
        do_reset(32'h0);
        k_pc_valid = 1'b1;
        t0 = cyc;
        repeat (8) step();
        chk_seq(32'h0, 6);
        for (int k = 0; k < 6 && k < got_cyc.size(); k++)
            chk("stream_cycle", W'(got_cyc[k]), W'(t0 + 2 + k));

        // 2: decode back-pressure fills the queue and stops requests
        do_reset(32'h0);
        k_pc_valid = 1'b1; k_id_ready = 1'b0;
        repeat (3) step();
        chk("full_req_valid", W'(s_req_valid), W'(0));
        chk("full_pc_stall", W'(s_stall), W'(1));
        chk("full_if_pc", s_if_pc, 32'h0);
        repeat (2) step();
        chk("full_no_delivery", W'(got_pc.size()), W'(0));
        k_id_ready = 1'b1;
        repeat (6) step();
        chk_seq(32'h0, 6);

        // 3: memory refuses requests for three cycles
        do_reset(32'h0);
        k_pc_valid = 1'b1;
        repeat (3) step();
        k_ready = 1'b0;
        step();
        chk("noready_stall", W'(s_stall), W'(1));
        chk("noready_addr0", s_req_addr, 32'hC);
        step();
        chk("noready_addr1", s_req_addr, 32'hC);
        step();
        chk("noready_drained", W'(s_if_valid), W'(0));
        k_ready = 1'b1;
        repeat (6) step();
        chk_seq(32'h0, 7);

        // 4: flush with two requests in flight, no response that cycle
        do_reset(32'h0);
        k_pc_valid = 1'b1; k_mem_en = 1'b0;
        repeat (2) step();
        k_flush = 1'b1; k_target = 32'h100;
        step();
        chk("flush_req_valid", W'(s_req_valid), W'(0));
        k_flush = 1'b0; k_mem_en = 1'b1;
        repeat (6) step();
        chk_seq(32'h100, 3);
        if (got_inst.size() > 0) chk("flush_first_inst", got_inst[0], 32'h1300_0100);

        // 5: flush on the same cycle as a response, one more still owed
        do_reset(32'h0);
        k_pc_valid = 1'b1; k_mem_en = 1'b0;
        repeat (2) step();
        k_flush = 1'b1; k_target = 32'h200; k_mem_en = 1'b1;
        step();
        k_flush = 1'b0;
        repeat (6) step();
        chk_seq(32'h200, 4);

        // 6: reset with a full queue and a request outstanding
        do_reset(32'h0);
        k_pc_valid = 1'b1; k_id_ready = 1'b0;
        repeat (2) step();
        k_mem_en = 1'b0;
        step();
        chk("prerst_if_valid", W'(s_if_valid), W'(1));
        chk("prerst_stall", W'(s_stall), W'(1));
        k_rst = 1'b1;
        step();
        k_rst = 1'b0; k_pc_valid = 1'b0;
        step();
        chk_reset_outputs();
        got_pc.delete(); got_inst.delete(); got_cyc.delete();
        cur_pc = 32'h300; k_pc_valid = 1'b1; k_id_ready = 1'b1; k_mem_en = 1'b1;
        repeat (5) step();
        chk_seq(32'h300, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
